universal_shift_register: RTL and testbench

- Parametrised successor to the team's single-bit async-reset D flip-flop: WIDTH-bit register with asynchronous active-low reset and a synchronous operation selector.
- Operations: hold, shift, rotate, arithmetic shift, parallel load and synchronous preset/clear.
- Tracks the number of shifts since the last load and flags when a full word has been shifted through.
- Used as the serialiser/deserialiser and general-purpose state register in datapath blocks.

---
 rtl/shift_reg_pkg.sv | 23 ++
 rtl/shift_counter_sat.sv | 47 ++++
 rtl/universal_shift_register.sv | 101 ++++++++++
 tb/tb_universal_shift_register.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register family.
//   mode_t         : 3-bit operation selector type
//   MODE_*         : operation encodings
//   is_shift_mode  : true for the modes that move bits (and advance the shift count)
package shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHL  = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_ROL  = 3'b011;
  localparam mode_t MODE_ROR  = 3'b100;
  localparam mode_t MODE_LOAD = 3'b101;
  localparam mode_t MODE_ASR  = 3'b110;
  localparam mode_t MODE_CLR  = 3'b111;

  function automatic logic is_shift_mode(input mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_counter_sat.sv
// Saturating up-counter with synchronous clear and a registered terminal flag.
//   clk_i    : rising-edge clock
//   rst_ni   : asynchronous active-low reset (count and flag to 0)
//   clr_i    : synchronous clear (wins over inc_i)
//   inc_i    : increment by one, saturating at MAX
//   count_o  : current count
//   done_o   : registered, high while count_o == MAX
module shift_counter_sat #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          done_o
);

  logic [CW-1:0] count_q, count_d;
  logic          done_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CW'(MAX))) begin
      count_d = count_q + CW'(1);
    end
  end

  // The flag is computed from the next count so it rises on the same edge
  // the count reaches MAX.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= (count_d == CW'(MAX));
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, shift, rotate, arithmetic shift,
// parallel load, synchronous clear and synchronous preset, plus a saturating
// count of shifts since the last load/clear/preset.
//   clock_pos       : rising-edge clock
//   reset_neg       : asynchronous active-low reset (RESET_VALUE, count 0)
//   preset_neg      : synchronous active-low preset (PRESET_VALUE, count 0),
//                     overrides enable and mode
//   enable          : 0 holds all state
//   mode            : operation select (see shift_reg_pkg)
//   signal_in       : parallel load data
//   serial_in_msb   : bit entering the MSB on shift right
//   serial_in_lsb   : bit entering the LSB on shift left
//   signal_out      : register contents
//   signal_out_neg  : ~signal_out
//   serial_out_msb  : signal_out[WIDTH-1]
//   serial_out_lsb  : signal_out[0]
//   shift_count     : shifts since last load/clear/preset, saturating at WIDTH
//   word_done       : registered, high while shift_count == WIDTH
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic                       clock_pos,
  input  logic                       reset_neg,
  input  logic                       preset_neg,
  input  logic                       enable,
  input  mode_t                      mode,
  input  logic [WIDTH-1:0]           signal_in,
  input  logic                       serial_in_msb,
  input  logic                       serial_in_lsb,
  output logic [WIDTH-1:0]           signal_out,
  output logic [WIDTH-1:0]           signal_out_neg,
  output logic                       serial_out_msb,
  output logic                       serial_out_lsb,
  output logic [$clog2(WIDTH+1)-1:0] shift_count,
  output logic                       word_done
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             cnt_clr;
  logic             cnt_inc;

  // Next-state selection. Serial inputs are only looked at in the two
  // modes that consume them, so unused serial pins cannot leak X.
  always_comb begin
    data_d  = data_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (!preset_neg) begin
      data_d  = PRESET_VALUE;
      cnt_clr = 1'b1;
    end else if (enable) begin
      cnt_inc = is_shift_mode(mode);
      case (mode)
        MODE_HOLD: data_d = data_q;
        MODE_SHL:  data_d = {data_q[WIDTH-2:0], serial_in_lsb};
        MODE_SHR:  data_d = {serial_in_msb, data_q[WIDTH-1:1]};
        MODE_ROL:  data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        MODE_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
        MODE_LOAD: begin
          data_d  = signal_in;
          cnt_clr = 1'b1;
        end
        MODE_ASR:  data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        MODE_CLR: begin
          data_d  = RESET_VALUE;
          cnt_clr = 1'b1;
        end
        default:   data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clock_pos or negedge reset_neg) begin
    if (!reset_neg) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  shift_counter_sat #(
    .MAX (WIDTH)
  ) u_shift_counter (
    .clk_i   (clock_pos),
    .rst_ni  (reset_neg),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (shift_count),
    .done_o  (word_done)
  );

  assign signal_out     = data_q;
  assign signal_out_neg = ~data_q;
  assign serial_out_msb = data_q[WIDTH-1];
  assign serial_out_lsb = data_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: three register instances (WIDTH 8, 2, 32) share one
// stimulus stream; an arithmetic reference model predicts each edge and a
// separate monitor compares every output after each edge or async reset.
module tb_universal_shift_register;
  import shift_reg_pkg::*;

  localparam int WS [3] = '{8, 2, 32};
  localparam int RV [3] = '{0, 1, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preset_n = 1'b1;
  logic        en = 1'b0;
  mode_t       md = MODE_HOLD;
  logic [31:0] din = '0;
  logic        s_msb = 1'b0;
  logic        s_lsb = 1'b0;

  logic [7:0]  q8, qn8;   logic m8, l8, wd8;   logic [3:0] c8;
  logic [1:0]  q2, qn2;   logic m2, l2, wd2;   logic [1:0] c2;
  logic [31:0] q32, qn32; logic m32, l32, wd32; logic [5:0] c32;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8)) u_w8 (
    .clock_pos(clk), .reset_neg(rst_n), .preset_neg(preset_n), .enable(en), .mode(md),
    .signal_in(din[7:0]), .serial_in_msb(s_msb), .serial_in_lsb(s_lsb),
    .signal_out(q8), .signal_out_neg(qn8), .serial_out_msb(m8), .serial_out_lsb(l8),
    .shift_count(c8), .word_done(wd8));

  universal_shift_register #(.WIDTH(2), .RESET_VALUE(2'b01)) u_w2 (
    .clock_pos(clk), .reset_neg(rst_n), .preset_neg(preset_n), .enable(en), .mode(md),
    .signal_in(din[1:0]), .serial_in_msb(s_msb), .serial_in_lsb(s_lsb),
    .signal_out(q2), .signal_out_neg(qn2), .serial_out_msb(m2), .serial_out_lsb(l2),
    .shift_count(c2), .word_done(wd2));

  universal_shift_register #(.WIDTH(32), .RESET_VALUE(32'd1)) u_w32 (
    .clock_pos(clk), .reset_neg(rst_n), .preset_neg(preset_n), .enable(en), .mode(md),
    .signal_in(din), .serial_in_msb(s_msb), .serial_in_lsb(s_lsb),
    .signal_out(q32), .signal_out_neg(qn32), .serial_out_msb(m32), .serial_out_lsb(l32),
    .shift_count(c32), .word_done(wd32));

  // Per-instance views of the outputs, index 0 = W8, 1 = W2, 2 = W32.
  logic [2:0][31:0] aq, aqn;
  logic [2:0][5:0]  ac;
  logic [2:0]       amsb, alsb, awd;
  assign aq   = {q32, {30'd0, q2}, {24'd0, q8}};
  assign aqn  = {qn32, {30'd0, qn2}, {24'd0, qn8}};
  assign ac   = {c32, {4'd0, c2}, {2'd0, c8}};
  assign amsb = {m32, m2, m8};
  assign alsb = {l32, l2, l8};
  assign awd  = {wd32, wd2, wd8};

  typedef struct packed {
    logic [2:0][31:0] q;
    logic [2:0][5:0]  c;
    logic [2:0]       d;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  event  chk_ev;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  longint unsigned mq [3];
  int              mc [3];

  function automatic longint unsigned mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e.q[i] = mq[i][31:0];
      e.c[i] = 6'(mc[i]);
      e.d[i] = (mc[i] == WS[i]);
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = longint'(RV[i]);
      mc[i] = 0;
    end
  endtask

  // One rising edge, computed from the operation definitions with integer arithmetic.
  task automatic model_edge(input bit pre, input bit e, input mode_t m, input logic [31:0] d,
                            input bit smsb, input bit slsb);
    for (int i = 0; i < 3; i++) begin
      longint unsigned w   = longint'(WS[i]);
      longint unsigned msk = mask_of(WS[i]);
      longint unsigned top = 64'd1 << (w - 1);
      longint unsigned q   = mq[i];
      bit shifted = 1'b0;
      if (!pre) begin
        q = msk;
        mc[i] = 0;
      end else if (e) begin
        case (m)
          MODE_SHL:  begin q = (q * 2 + longint'(slsb)) & msk;           shifted = 1; end
          MODE_SHR:  begin q = q / 2 + (smsb ? top : 0);                 shifted = 1; end
          MODE_ROL:  begin q = ((q * 2) & msk) + (q >= top ? 1 : 0);     shifted = 1; end
          MODE_ROR:  begin q = q / 2 + ((q % 2 == 1) ? top : 0);         shifted = 1; end
          MODE_ASR:  begin q = q / 2 + (q >= top ? top : 0);             shifted = 1; end
          MODE_LOAD: begin q = longint'(d) & msk; mc[i] = 0; end
          MODE_CLR:  begin q = longint'(RV[i]);   mc[i] = 0; end
          default:   ;
        endcase
        if (shifted && mc[i] < WS[i]) mc[i] = mc[i] + 1;
      end
      mq[i] = q;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Drive one clocked operation (reset released).
  task automatic cyc(input string tag, input bit pre, input bit e, input mode_t m,
                     input logic [31:0] d, input bit smsb, input bit slsb);
    @(negedge clk);
    rst_n = 1'b1; preset_n = pre; en = e; md = m; din = d; s_msb = smsb; s_lsb = slsb;
    model_edge(pre, e, m, d, smsb, slsb);
    push_exp(tag);
    $display("op %-8s pre=%0b en=%0b mode=%03b din=%08h smsb=%0b slsb=%0b", tag, pre, e, m, d, smsb, slsb);
  endtask

  // Assert reset between edges; check immediately, then once more after the next edge.
  task automatic async_reset(input string tag, input bit pre);
    @(negedge clk);
    #2;
    rst_n = 1'b0; preset_n = pre;
    model_reset();
    push_exp({tag, "_now"});
    ->chk_ev;
    push_exp({tag, "_edge"});
    $display("op %-8s async reset asserted preset_n=%0b", tag, pre);
  endtask

  // Monitor: pops one expectation per rising edge (or async-reset event).
  initial begin
    exp_t  e;
    string t;
    longint unsigned msk;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          msk = mask_of(WS[i]);
          chk($sformatf("%s w%0d q", t, WS[i]),    64'(aq[i]),   64'(e.q[i]));
          chk($sformatf("%s w%0d qn", t, WS[i]),   64'(aqn[i]),  64'(~longint'(e.q[i]) & msk));
          chk($sformatf("%s w%0d smsb", t, WS[i]), 64'(amsb[i]), 64'((longint'(e.q[i]) >> (WS[i] - 1)) & 1));
          chk($sformatf("%s w%0d slsb", t, WS[i]), 64'(alsb[i]), 64'(e.q[i][0]));
          chk($sformatf("%s w%0d cnt", t, WS[i]),  64'(ac[i]),   64'(e.c[i]));
          chk($sformatf("%s w%0d done", t, WS[i]), 64'(awd[i]),  64'(e.d[i]));
        end
      end
    end
  end

  initial begin
    bit [7:0] sbits;
    model_reset();
    async_reset("init", 1'b1);
    cyc("load3c", 1, 1, MODE_LOAD, 32'h0000_003C, 0, 0);

    // Async reset mid-cycle with A5 in the register, then reload
    cyc("loada5", 1, 1, MODE_LOAD, 32'hFFFF_FFA5, 0, 0);
    async_reset("rst_mid", 1'b1);
    cyc("load3c", 1, 1, MODE_LOAD, 32'h0000_003C, 0, 0);

    // Shift-left serialise, including one shift past saturation
    cyc("loada5", 1, 1, MODE_LOAD, 32'h5A5A_5AA5, 0, 0);
    for (int k = 0; k < 9; k++) cyc("shl", 1, 1, MODE_SHL, 32'hDEAD_BEEF, 1, 0);

    // Rotate and arithmetic shift
    cyc("load81", 1, 1, MODE_LOAD, 32'h8000_0081, 0, 0);
    cyc("rol", 1, 1, MODE_ROL, '0, 0, 0);
    cyc("ror", 1, 1, MODE_ROR, '0, 0, 0);
    cyc("ror", 1, 1, MODE_ROR, '0, 0, 0);
    cyc("asr", 1, 1, MODE_ASR, '0, 0, 0);
    cyc("load40", 1, 1, MODE_LOAD, 32'h4000_0040, 0, 0);
    cyc("asr", 1, 1, MODE_ASR, '0, 0, 0);

    // Priority
    cyc("load5a", 1, 1, MODE_LOAD, 32'h1234_565A, 0, 0);
    cyc("en0shl", 1, 0, MODE_SHL, '0, 1, 1);
    cyc("hold", 1, 1, MODE_HOLD, 32'hFFFF_FFFF, 1, 1);
    cyc("preset", 0, 0, MODE_LOAD, 32'h0000_0011, 0, 0);
    async_reset("rst_pre", 1'b0);

    // Shift-right deserialise, then clear
    sbits = 8'b1100_1010;
    for (int k = 0; k < 8; k++) cyc("shr", 1, 1, MODE_SHR, '0, sbits[7-k], 1);
    cyc("clr", 1, 1, MODE_CLR, 32'hFFFF_FFFF, 1, 1);

    // Randomised operation mix with occasional preset and async reset
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rnd_rst", 1'($urandom_range(0, 1)));
      end else begin
        cyc("rnd", ($urandom_range(0, 19) != 0), ($urandom_range(0, 7) != 0),
            mode_t'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      end
    end

    // Bounded drain of the scoreboard
    repeat (4) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
